// File: rtl/spi_master_rx_multi.sv
// Multi-lane (std/dual/quad) SPI receive path: packs sampled lanes into words and queues them in a small FIFO.
// Define SPI_RX_LSB_FIRST_EN to add the lsb_first port for LSB-first shifting.
module spi_master_rx_multi #(
    parameter int WORD_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              rx_edge,
    input  logic [1:0]        mode,
    input  logic [3:0]        sdi,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              counter_in_upd,
`ifdef SPI_RX_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              rx_done,
    output logic [WORD_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WC_W  = $clog2(WORD_W) + 1;

    typedef enum logic {IDLE, RECV} state_t;

    state_t              state;
    logic [1:0]          lanes_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    beat_cnt;
    logic [WC_W-1:0]     word_cnt;
    logic [WORD_W-1:0]   shift;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;

    logic                beat;
    logic                final_beat;
    logic                word_done;
    logic                pop;
    logic                push_ok;
    logic                full;
    logic                empty;
    logic                lsb_eff;
    logic [1:0]          mode_lanes;
    logic [1:0]          lanes_eff;
    logic [CNT_W:0]      bits_eff;
    logic [CNT_W:0]      beat_target;
    logic [CNT_W:0]      beat_next;
    logic [WC_W-1:0]     word_beats;
    logic [WORD_W-1:0]   shift_next;

    // Lane code: 0 = one lane, 1 = two lanes, 2 = four lanes.
    always_comb begin
        case (mode)
            2'b01:   mode_lanes = 2'd1;
            2'b10:   mode_lanes = 2'd2;
            default: mode_lanes = 2'd0;
        endcase
    end

    assign lanes_eff = (state == IDLE) ? mode_lanes : lanes_q;

`ifdef SPI_RX_LSB_FIRST_EN
    logic lsb_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lsb_q <= 1'b0;
        end else if (rx_edge && en && state == IDLE) begin
            lsb_q <= lsb_first;
        end
    end

    assign lsb_eff = (state == IDLE) ? lsb_first : lsb_q;
`else
    assign lsb_eff = 1'b0;
`endif

    assign beat     = rx_edge & en;
    assign bits_eff = (bit_cnt == '0) ? (CNT_W+1)'(1) : {1'b0, bit_cnt};

    always_comb begin
        case (lanes_eff)
            2'd1: begin
                beat_target = (bits_eff + (CNT_W+1)'(1)) >> 1;
                word_beats  = WC_W'(WORD_W / 2);
            end
            2'd2: begin
                beat_target = (bits_eff + (CNT_W+1)'(3)) >> 2;
                word_beats  = WC_W'(WORD_W / 4);
            end
            default: begin
                beat_target = bits_eff;
                word_beats  = WC_W'(WORD_W);
            end
        endcase
    end

    // A target lowered mid-transfer below the beats already taken ends the transfer on the next beat.
    assign beat_next  = {1'b0, beat_cnt} + (CNT_W+1)'(1);
    assign final_beat = beat_next >= beat_target;
    assign rx_done    = beat & final_beat;
    assign word_done  = beat & (((word_cnt + WC_W'(1)) == word_beats) | final_beat);

    always_comb begin
        shift_next = shift;
        case (lanes_eff)
            2'd1:    shift_next = lsb_eff ? {sdi[1:0], shift[WORD_W-1:2]}
                                          : {shift[WORD_W-3:0], sdi[1:0]};
            2'd2:    shift_next = lsb_eff ? {sdi[3:0], shift[WORD_W-1:4]}
                                          : {shift[WORD_W-5:0], sdi[3:0]};
            default: shift_next = lsb_eff ? {sdi[0], shift[WORD_W-1:1]}
                                          : {shift[WORD_W-2:0], sdi[0]};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            lanes_q  <= 2'd0;
            bit_cnt  <= CNT_W'(8);
            beat_cnt <= '0;
            word_cnt <= '0;
            shift    <= '0;
        end else begin
            if (counter_in_upd) begin
                bit_cnt <= counter_in;
            end
            if (beat) begin
                if (state == IDLE) begin
                    lanes_q <= mode_lanes;
                end
                shift    <= word_done ? '0 : shift_next;
                word_cnt <= word_done ? '0 : word_cnt + WC_W'(1);
                if (final_beat) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end else begin
                    state    <= RECV;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                          (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop          = ~empty & data_ready_i;
    assign push_ok      = word_done & (~full | pop);
    assign data_valid_o = ~empty;
    assign data_o       = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= shift_next;
        end
    end

    // A word lost to a full FIFO is reported even if a count reload lands in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if (word_done && full && !pop) begin
                overflow_o <= 1'b1;
            end else if (counter_in_upd) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_rx_multi.sv
// Scoreboard testbench for spi_master_rx_multi: directed transfers plus randomized ones checked against a word-packing model.
`timescale 1ns/1ps
module tb_spi_master_rx_multi;

    localparam int WORD_W     = 32;
    localparam int CNT_W      = 16;
    localparam int FIFO_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              en = 1'b0;
    logic              rx_edge = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [3:0]        sdi = 4'h0;
    logic [CNT_W-1:0]  counter_in = '0;
    logic              counter_in_upd = 1'b0;
    logic              rx_done;
    logic [WORD_W-1:0] data_o;
    logic              data_valid_o;
    logic              data_ready_i = 1'b1;
    logic              overflow_o;

    int vectors = 0;
    int miscompares = 0;

    logic [WORD_W-1:0] exp_q[$];
    logic [3:0]        beats[$];

    always #5 clk = ~clk;

    spi_master_rx_multi #(
        .WORD_W(WORD_W),
        .CNT_W(CNT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .rx_edge(rx_edge),
        .mode(mode),
        .sdi(sdi),
        .counter_in(counter_in),
        .counter_in_upd(counter_in_upd),
        .rx_done(rx_done),
        .data_o(data_o),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .overflow_o(overflow_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int lanes_of(input logic [1:0] m);
        if (m == 2'b01) return 2;
        if (m == 2'b10) return 4;
        return 1;
    endfunction

    function automatic int beats_of(input int bits, input int lanes);
        return (bits == 0) ? 1 : (bits + lanes - 1) / lanes;
    endfunction

    // Every word leaving the FIFO is compared against the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && data_valid_o && data_ready_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", data_o);
                end else begin
                    checkOutput("word", data_o, exp_q.pop_front());
                end
            end
        end
    end

    // Reference: a transfer is a stream of L-bit digits grouped WORD_W/L at a time, the tail group right-justified.
    task automatic model_push(input int bits, input logic [1:0] m);
        int lanes = lanes_of(m);
        int nb = beats_of(bits, lanes);
        int per = WORD_W / lanes;
        int cnt = 0;
        longint unsigned radix = longint'(1) << lanes;
        longint unsigned acc = 0;
        for (int i = 0; i < nb; i++) begin
            acc = acc * radix + (longint'(beats[i]) % radix);
            cnt++;
            if (cnt == per || i == nb - 1) begin
                exp_q.push_back(WORD_W'(acc));
                acc = 0;
                cnt = 0;
            end
        end
    endtask

    task automatic load_pattern(input logic [63:0] value, input int nb, input int lanes);
        longint unsigned mask = (longint'(1) << lanes) - 1;
        beats.delete();
        for (int i = 0; i < nb; i++) begin
            longint unsigned digit = (value >> ((nb - 1 - i) * lanes)) & mask;
            longint unsigned junk  = longint'($urandom_range(15, 0)) & ~mask & 64'hF;
            beats.push_back(4'(digit | junk));
        end
    endtask

    task automatic load_random(input int nb);
        beats.delete();
        for (int i = 0; i < nb; i++) beats.push_back(4'($urandom_range(15, 0)));
    endtask

    task automatic pulse_upd(input int bits);
        @(posedge clk); #1;
        counter_in = CNT_W'(bits);
        counter_in_upd = 1'b1;
        @(posedge clk); #1;
        counter_in_upd = 1'b0;
    endtask

    // Entered and left just after a rising edge; abort_at >= 0 pulses reset instead of that beat.
    task automatic applyStimulus(input int bits, input logic [1:0] m, input int en_drops,
                                 input int max_gap, input bit do_upd, input int abort_at);
        int nb = beats_of(bits, lanes_of(m));
        int drop_at = nb / 2;
        if (do_upd) pulse_upd(bits);
        mode = m;
        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) begin
                rstn = 1'b0;
                #3;
                checkOutput("reset_valid", data_valid_o, 0);
                checkOutput("reset_data", data_o, 0);
                checkOutput("reset_overflow", overflow_o, 0);
                checkOutput("reset_rx_done", rx_done, 0);
                @(posedge clk); #1;
                rstn = 1'b1;
                return;
            end
            if (i == drop_at) begin
                for (int k = 0; k < en_drops; k++) begin
                    en = 1'b0;
                    rx_edge = 1'b1;
                    sdi = 4'($urandom_range(15, 0));
                    @(negedge clk);
                    checkOutput("rx_done_en_low", rx_done, 0);
                    @(posedge clk); #1;
                    rx_edge = 1'b0;
                    en = 1'b1;
                end
            end
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk); #1;
            end
            en = 1'b1;
            rx_edge = 1'b1;
            sdi = beats[i];
            @(negedge clk);
            checkOutput($sformatf("rx_done_beat%0d", i + 1), rx_done, (i == nb - 1));
            @(posedge clk); #1;
            rx_edge = 1'b0;
            mode = 2'($urandom_range(3, 0));
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_drain: got %0d words pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int bits;
        logic [1:0] m;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", data_valid_o, 0);
        checkOutput("reset_data", data_o, 0);
        checkOutput("reset_overflow", overflow_o, 0);
        checkOutput("reset_rx_done", rx_done, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        en = 1'b1;

        $display("[TB] std mode, 32 bits");
        load_pattern(64'hA5A5F00F, 32, 1);
        exp_q.push_back(32'hA5A5F00F);
        applyStimulus(32, 2'b00, 0, 0, 1'b1, -1);
        wait_drain("std32");

        $display("[TB] quad mode, 64 bits");
        load_pattern(64'h0123456789ABCDEF, 16, 4);
        exp_q.push_back(32'h01234567);
        exp_q.push_back(32'h89ABCDEF);
        applyStimulus(64, 2'b10, 0, 2, 1'b1, -1);
        wait_drain("quad64");

        $display("[TB] dual mode, 10 bits");
        beats.delete();
        beats.push_back(4'b0011); beats.push_back(4'b1101); beats.push_back(4'b0110);
        beats.push_back(4'b1000); beats.push_back(4'b0111);
        exp_q.push_back(32'h00000363);
        applyStimulus(10, 2'b01, 0, 1, 1'b1, -1);
        wait_drain("dual10_a");
        beats.delete();
        beats.push_back(4'b0011); beats.push_back(4'b0010); beats.push_back(4'b1110);
        beats.push_back(4'b0100); beats.push_back(4'b1011);
        exp_q.push_back(32'h000003A3);
        applyStimulus(10, 2'b01, 0, 1, 1'b1, -1);
        wait_drain("dual10_b");

        $display("[TB] enable dropped mid-word");
        load_pattern(64'hA5A5F00F, 32, 1);
        exp_q.push_back(32'hA5A5F00F);
        applyStimulus(32, 2'b00, 5, 1, 1'b1, -1);
        wait_drain("en_drop");

        $display("[TB] zero-length transfer, mode 11");
        beats.delete();
        beats.push_back(4'b0111);
        exp_q.push_back(32'h00000001);
        applyStimulus(0, 2'b11, 0, 0, 1'b1, -1);
        wait_drain("bits0");

        $display("[TB] FIFO overflow");
        data_ready_i = 1'b0;
        load_random(96);
        model_push(96, 2'b00);
        while (exp_q.size() > FIFO_DEPTH) exp_q.pop_back();
        applyStimulus(96, 2'b00, 0, 0, 1'b1, -1);
        checkOutput("overflow_set", overflow_o, 1);
        checkOutput("overflow_valid", data_valid_o, 1);
        data_ready_i = 1'b1;
        wait_drain("overflow");
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("overflow_drained", data_valid_o, 0);
        checkOutput("overflow_sticky", overflow_o, 1);
        pulse_upd(8);
        checkOutput("overflow_cleared", overflow_o, 0);

        $display("[TB] reset mid-transfer");
        data_ready_i = 1'b0;
        load_random(8);
        applyStimulus(8, 2'b00, 0, 0, 1'b1, -1);
        checkOutput("queued_before_reset", data_valid_o, 1);
        load_random(32);
        applyStimulus(32, 2'b00, 0, 1, 1'b1, 6);
        data_ready_i = 1'b1;
        load_random(8);
        model_push(8, 2'b00);
        applyStimulus(8, 2'b00, 0, 1, 1'b0, -1);
        wait_drain("after_reset");

        $display("[TB] randomized transfers");
        for (int t = 0; t < 25; t++) begin
            bits = $urandom_range(100, 0);
            m = 2'($urandom_range(3, 0));
            load_random(beats_of(bits, lanes_of(m)));
            model_push(bits, m);
            applyStimulus(bits, m, $urandom_range(3, 0), 2, 1'b1, -1);
            wait_drain($sformatf("random%0d", t));
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("final_valid", data_valid_o, 0);
        checkOutput("final_overflow", overflow_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
